// File: rtl/instruction_fetch_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : instruction_fetch_pkg
//  Brief    : Shared widths, PC constants and ROM image for the IF stage.
//  Revision : 1.0
// ============================================================================
package instruction_fetch_pkg;

    localparam int unsigned c_IWIDTH   = 32;
    localparam int unsigned c_AWIDTH   = 32;
    localparam logic [31:0] c_RESET_PC = 32'h0000_0000;
    localparam logic [31:0] c_PC_INCR  = 32'h0000_0004;
    localparam logic [31:0] c_ROM_BASE = 32'h1000_0000;

    // Program image: word i holds c_ROM_BASE + i; words past the program read as zero.
    function automatic logic [31:0] rom_image(input logic [31:0] idx, input int unsigned prog_len);
        if (idx < prog_len) begin
            return c_ROM_BASE + idx;
        end
        return '0;
    endfunction

endpackage
`default_nettype wire

// File: rtl/instruction_memory.sv
`default_nettype none
// ============================================================================
//  Module   : instruction_memory
//  Brief    : Private instruction ROM with syn/ack handshake and last-word flag.
//  Revision : 1.0
// ============================================================================
module instruction_memory
    import instruction_fetch_pkg::*;
#(
    parameter int unsigned IWIDTH   = c_IWIDTH,
    parameter int unsigned AWIDTH   = c_AWIDTH,
    parameter int unsigned DEPTH    = 1024,
    parameter int unsigned PROG_LEN = 8
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_stall,
    input  logic              i_flush,
    input  logic              i_syn,
    input  logic [AWIDTH-1:0] i_pc,
    output logic              o_req_last,
    output logic              o_ack,
    output logic              o_last,
    output logic [IWIDTH-1:0] o_data,
    output logic [AWIDTH-1:0] o_addr
);

    localparam int unsigned      c_IDXW     = $clog2(DEPTH);
    localparam logic [AWIDTH-3:0] c_LAST_IDX = (AWIDTH-2)'(PROG_LEN - 1);

    logic [c_IDXW-1:0] w_idx;
    logic [IWIDTH-1:0] w_word;

    // Word index wraps modulo DEPTH; the last-word test uses the full index.
    assign w_idx      = i_pc[c_IDXW+1:2];
    assign w_word     = IWIDTH'(rom_image({{(32-c_IDXW){1'b0}}, w_idx}, PROG_LEN));
    assign o_req_last = (i_pc[AWIDTH-1:2] == c_LAST_IDX);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_ack  <= 1'b0;
            o_last <= 1'b0;
            o_data <= '0;
            o_addr <= '0;
        end else if (i_flush) begin
            o_ack  <= 1'b0;
            o_last <= 1'b0;
        end else if (!i_stall) begin
            o_ack <= i_syn;
            if (i_syn) begin
                o_data <= w_word;
                o_addr <= i_pc;
                o_last <= o_req_last;
            end else begin
                o_last <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/instruction_fetch.sv
`default_nettype none
// ============================================================================
//  Module   : instruction_fetch
//  Brief    : IF stage: PC register, fetch-done flag, redirect/squash, ROM.
//  Revision : 1.0
// ============================================================================
module instruction_fetch
    import instruction_fetch_pkg::*;
#(
    parameter int unsigned IWIDTH   = c_IWIDTH,
    parameter int unsigned AWIDTH   = c_AWIDTH,
    parameter int unsigned DEPTH    = 1024,
    parameter int unsigned PROG_LEN = 8
) (
    input  logic              f_i_clk,
    input  logic              f_i_rst,
    input  logic              f_i_ce,
    input  logic              f_i_stall,
    input  logic              f_i_change_pc,
    input  logic [AWIDTH-1:0] f_i_pc,
    output logic [IWIDTH-1:0] f_o_instr,
    output logic [AWIDTH-1:0] f_o_pc,
    output logic              f_o_ce
);

    localparam logic [AWIDTH-1:0] c_ALIGN_MASK = ~AWIDTH'(3);

    logic [AWIDTH-1:0] r_pc;
    logic              r_done;
    logic              w_syn;
    logic              w_req_last;
    logic              w_ack;
    logic              w_last;

    assign w_syn = f_i_ce & ~f_i_stall & ~r_done & ~f_i_change_pc;

    // done rises on the edge that issues the last word, so no request follows it.
    always_ff @(posedge f_i_clk or posedge f_i_rst) begin
        if (f_i_rst) begin
            r_pc   <= AWIDTH'(c_RESET_PC);
            r_done <= 1'b0;
        end else if (f_i_change_pc) begin
            r_pc   <= f_i_pc & c_ALIGN_MASK;
            r_done <= 1'b0;
        end else if (w_syn) begin
            r_pc <= r_pc + AWIDTH'(c_PC_INCR);
            if (w_req_last) begin
                r_done <= 1'b1;
            end
        end
    end

    instruction_memory #(
        .IWIDTH   (IWIDTH),
        .AWIDTH   (AWIDTH),
        .DEPTH    (DEPTH),
        .PROG_LEN (PROG_LEN)
    ) u_imem (
        .i_clk      (f_i_clk),
        .i_rst      (f_i_rst),
        .i_stall    (f_i_stall),
        .i_flush    (f_i_change_pc),
        .i_syn      (w_syn),
        .i_pc       (r_pc),
        .o_req_last (w_req_last),
        .o_ack      (w_ack),
        .o_last     (w_last),
        .o_data     (f_o_instr),
        .o_addr     (f_o_pc)
    );

    assign f_o_ce = w_ack;

endmodule
`default_nettype wire

// File: tb/tb_instruction_fetch.sv
`default_nettype none
// ============================================================================
//  Module   : tb_instruction_fetch
//  Brief    : Directed vector bench for the IF stage (image word i = 1000_0000+i).
//  Revision : 1.0
// ============================================================================
module tb_instruction_fetch;

    logic        clk;
    logic        rst;
    logic        ce;
    logic        stall;
    logic        change_pc;
    logic [31:0] tpc;
    logic [31:0] instr;
    logic [31:0] opc;
    logic        oce;

    int n_cmp;
    int n_err;

    typedef struct {
        bit          rst;
        bit          ce;
        bit          stall;
        bit          chg;
        logic [31:0] tpc;
        bit          e_ce;
        logic [31:0] e_instr;
        logic [31:0] e_pc;
        bit          e_last;
    } vec_t;

    vec_t vecs[$];

    instruction_fetch dut (
        .f_i_clk       (clk),
        .f_i_rst       (rst),
        .f_i_ce        (ce),
        .f_i_stall     (stall),
        .f_i_change_pc (change_pc),
        .f_i_pc        (tpc),
        .f_o_instr     (instr),
        .f_o_pc        (opc),
        .f_o_ce        (oce)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] w(input int i);
        return 32'h1000_0000 + 32'(i);
    endfunction

    function automatic void add(input bit r, input bit c, input bit s, input bit g,
                                input logic [31:0] t, input bit eo, input logic [31:0] ei,
                                input logic [31:0] ep, input bit el);
        vec_t v;
        v.rst = r; v.ce = c; v.stall = s; v.chg = g; v.tpc = t;
        v.e_ce = eo; v.e_instr = ei; v.e_pc = ep; v.e_last = el;
        vecs.push_back(v);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_vec(input int k, input vec_t v);
        check($sformatf("v%0d f_o_ce", k), 32'(oce), 32'(v.e_ce));
        check($sformatf("v%0d f_o_instr", k), instr, v.e_instr);
        check($sformatf("v%0d f_o_pc", k), opc, v.e_pc);
        check($sformatf("v%0d last", k), 32'(dut.w_last), 32'(v.e_last));
    endtask

    task automatic do_reset();
        @(negedge clk);
        ce = 0; stall = 0; change_pc = 0; tpc = '0;
        rst = 1'b1;
        #1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        n_cmp = 0; n_err = 0;
        rst = 1'b1; ce = 0; stall = 0; change_pc = 0; tpc = '0;

        // sequential run, done state, redirect after done, index/PC wrap, misaligned target
        add(1,0,0,0,0, 0,0,0,0);
        for (int i = 0; i < 8; i++) add(0,1,0,0,0, 1,w(i),32'(4*i),(i == 7));
        add(0,1,0,0,0, 0,w(7),32'h1C,0);
        add(0,1,0,0,0, 0,w(7),32'h1C,0);
        add(0,1,0,1,32'h18, 0,w(7),32'h1C,0);
        add(0,1,0,0,0, 1,w(6),32'h18,0);
        add(0,1,0,0,0, 1,w(7),32'h1C,1);
        add(0,1,0,0,0, 0,w(7),32'h1C,0);
        add(0,1,0,1,32'hFFC, 0,w(7),32'h1C,0);
        add(0,1,0,0,0, 1,32'h0,32'hFFC,0);
        add(0,1,0,0,0, 1,w(0),32'h1000,0);
        add(0,1,0,1,32'hFFFF_FFFC, 0,w(0),32'h1000,0);
        add(0,1,0,0,0, 1,32'h0,32'hFFFF_FFFC,0);
        add(0,1,0,0,0, 1,w(0),32'h0,0);
        add(0,1,0,0,0, 1,w(1),32'h4,0);
        add(0,1,0,1,32'h13, 0,w(1),32'h4,0);
        add(0,1,0,0,0, 1,w(4),32'h10,0);
        // stall three cycles on word 2, then stall+redirect
        add(1,0,0,0,0, 0,0,0,0);
        for (int i = 0; i < 3; i++) add(0,1,0,0,0, 1,w(i),32'(4*i),0);
        for (int i = 0; i < 3; i++) add(0,1,1,0,0, 1,w(2),32'h8,0);
        add(0,1,0,0,0, 1,w(3),32'hC,0);
        add(0,1,0,0,0, 1,w(4),32'h10,0);
        add(0,1,1,1,32'h8, 0,w(4),32'h10,0);
        add(0,1,0,0,0, 1,w(2),32'h8,0);
        // redirect while requesting word 1
        add(1,0,0,0,0, 0,0,0,0);
        add(0,1,0,0,0, 1,w(0),32'h0,0);
        add(0,1,0,1,32'h10, 0,w(0),32'h0,0);
        add(0,1,0,0,0, 1,w(4),32'h10,0);
        add(0,1,0,0,0, 1,w(5),32'h14,0);
        // ce low after word 3
        add(1,0,0,0,0, 0,0,0,0);
        for (int i = 0; i < 4; i++) add(0,1,0,0,0, 1,w(i),32'(4*i),0);
        add(0,0,0,0,0, 0,w(3),32'hC,0);
        add(0,0,0,0,0, 0,w(3),32'hC,0);
        add(0,1,0,0,0, 1,w(4),32'h10,0);

        for (int k = 0; k < vecs.size(); k++) begin
            if (vecs[k].rst) begin
                @(negedge clk);
                ce = 0; stall = 0; change_pc = 0; tpc = '0;
                rst = 1'b1;
                #1;
                check_vec(k, vecs[k]);
                @(negedge clk);
                rst = 1'b0;
            end else begin
                @(negedge clk);
                ce = vecs[k].ce; stall = vecs[k].stall;
                change_pc = vecs[k].chg; tpc = vecs[k].tpc;
                @(posedge clk);
                #1;
                check_vec(k, vecs[k]);
            end
        end

        // PC parks at 0x20 once the last word has gone out
        do_reset();
        ce = 1'b1;
        repeat (12) @(posedge clk);
        #1;
        check("pc after done", dut.r_pc, 32'h20);
        check("ce after done", 32'(oce), 32'h0);
        check("instr after done", instr, w(7));

        // asynchronous reset between edges
        do_reset();
        ce = 1'b1;
        repeat (3) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check("async rst ce", 32'(oce), 32'h0);
        check("async rst instr", instr, 32'h0);
        check("async rst pc", opc, 32'h0);
        check("async rst rpc", dut.r_pc, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("restart ce", 32'(oce), 32'h1);
        check("restart instr", instr, w(0));
        check("restart pc", opc, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
